// File: rtl/rv_structs.sv
// rtl/rv_structs.sv - shared types and encodings for the load/store unit
// Contents:
//   lsu_state_t         sequencer states (idle, bus access in flight)
//   F3_B/H/W/BU/HU      funct3 access size/sign encodings for loads and stores
package rv_structs;

    typedef enum logic [0:0] {
        LSU_IDLE   = 1'b0,
        LSU_ACCESS = 1'b1
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/rv_lsu_ld_align.sv
// rtl/rv_lsu_ld_align.sv - selects and extends the loaded byte/half/word
// Ports:
//   rdata    in  32  raw bus read data
//   addr_lo  in  2   low address bits of the load
//   funct3   in  3   load size/sign
//   data     out 32  aligned, sign- or zero-extended load data
module rv_lsu_ld_align
    import rv_structs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        sel_b = rdata[7:0];
        case (addr_lo)
            2'd0: sel_b = rdata[7:0];
            2'd1: sel_b = rdata[15:8];
            2'd2: sel_b = rdata[23:16];
            2'd3: sel_b = rdata[31:24];
            default: sel_b = rdata[7:0];
        endcase
        sel_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    data = {{24{sel_b[7]}}, sel_b};
            F3_BU:   data = {24'd0, sel_b};
            F3_H:    data = {{16{sel_h[15]}}, sel_h};
            F3_HU:   data = {16'd0, sel_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/rv_lsu_ctrl.sv
// rtl/rv_lsu_ctrl.sv - load/store sequencer between execute stage and data bus
// Optional build macro: RV_LSU_MISALIGN_EN (reject misaligned half/word ops, adds o_misalign)
// Ports:
//   i_clk, i_reset_n                 clock, synchronous active-low reset
//   i_valid/i_load/i_store           execute-stage op qualifiers
//   i_addr/i_wdata/i_wsel/i_funct3   op address, store data, byte enables, size/sign
//   i_rd                             load destination register
//   o_stall                          holds execute and upstream stages
//   o_ld_valid/o_ld_data/o_ld_rd     one-cycle load writeback
//   o_bus_req/we/addr/wdata/wsel     registered data-bus request
//   i_bus_ack/i_bus_rdata            bus completion and read data
//   o_bus_err                        one-cycle pulse on timeout abort
//   o_misalign                       one-cycle pulse on rejected op (macro only)
module rv_lsu_ctrl
    import rv_structs::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_valid,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wsel,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    output logic        o_stall,
    output logic        o_ld_valid,
    output logic [31:0] o_ld_data,
    output logic [4:0]  o_ld_rd,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wsel,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
`ifdef RV_LSU_MISALIGN_EN
    output logic        o_misalign,
`endif
    output logic        o_bus_err
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_t       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             mem_op;
    logic             op_take;
    logic             op_start;
    logic             timeout_hit;
    logic             op_load;
    logic [1:0]       op_addr_lo;
    logic [2:0]       op_funct3;
    logic [4:0]       op_rd;
    logic [31:0]      ld_ext;

    assign mem_op = i_valid & (i_load | i_store);

`ifdef RV_LSU_MISALIGN_EN
    logic bad_align;

    assign bad_align = (((i_funct3 == F3_H) || (i_funct3 == F3_HU)) && i_addr[0])
                     || ((i_funct3 == F3_W) && (i_addr[1:0] != 2'b00));
    // The cycle after a rejection is a release cycle: the held op is not
    // re-examined, so the stall lasts exactly one cycle.
    assign op_take  = mem_op & ~o_misalign;
    assign op_start = op_take & ~bad_align;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_misalign <= 1'b0;
        end else begin
            o_misalign <= (state == LSU_IDLE) & op_take & bad_align;
        end
    end
`else
    assign op_take  = mem_op;
    assign op_start = mem_op;
`endif

    // Ack in the same cycle as the last count wins over the abort.
    assign timeout_hit = (TIMEOUT > 0) && (state == LSU_ACCESS)
                      && (count == CNT_LAST) && !i_bus_ack;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= LSU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_stall   = 1'b0;
        case (state)
            LSU_IDLE: begin
                o_stall = op_take;
                if (op_start) begin
                    state_nxt = LSU_ACCESS;
                end
            end
            LSU_ACCESS: begin
                o_stall = ~i_bus_ack & ~timeout_hit;
                if (i_bus_ack || timeout_hit) begin
                    state_nxt = LSU_IDLE;
                end
            end
            default: state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if ((state == LSU_IDLE) && op_start) begin
            count <= '0;
        end else if ((state == LSU_ACCESS) && !i_bus_ack) begin
            count <= count + CNT_W'(1);
        end
    end

    rv_lsu_ld_align u_ld_align (
        .rdata   (i_bus_rdata),
        .addr_lo (op_addr_lo),
        .funct3  (op_funct3),
        .data    (ld_ext)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_ld_valid  <= 1'b0;
            o_ld_data   <= '0;
            o_ld_rd     <= '0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_bus_wsel  <= '0;
            o_bus_err   <= 1'b0;
            op_load     <= 1'b0;
            op_addr_lo  <= '0;
            op_funct3   <= '0;
            op_rd       <= '0;
        end else begin
            o_ld_valid <= 1'b0;
            o_bus_err  <= 1'b0;
            if ((state == LSU_IDLE) && op_start) begin
                o_bus_req   <= 1'b1;
                o_bus_we    <= i_store;
                o_bus_addr  <= {i_addr[31:2], 2'b00};
                o_bus_wdata <= i_wdata;
                o_bus_wsel  <= i_store ? i_wsel : 4'b1111;
                op_load     <= i_load;
                op_addr_lo  <= i_addr[1:0];
                op_funct3   <= i_funct3;
                op_rd       <= i_rd;
            end else if (state == LSU_ACCESS) begin
                if (i_bus_ack) begin
                    o_bus_req <= 1'b0;
                    if (op_load) begin
                        o_ld_valid <= 1'b1;
                        o_ld_data  <= ld_ext;
                        o_ld_rd    <= op_rd;
                    end
                end else if (timeout_hit) begin
                    o_bus_req <= 1'b0;
                    o_bus_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_lsu_ctrl.sv
// tb/tb_rv_lsu_ctrl.sv - directed self-checking bench for rv_lsu_ctrl
module tb_rv_lsu_ctrl;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic        clk;
    logic        i_reset_n;
    logic        i_valid, i_load, i_store;
    logic [31:0] i_addr, i_wdata;
    logic [3:0]  i_wsel;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd;
    logic        o_stall, o_ld_valid;
    logic [31:0] o_ld_data;
    logic [4:0]  o_ld_rd;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_wsel;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_bus_err;
`ifdef RV_LSU_MISALIGN_EN
    logic        o_misalign;
`endif

    int errors = 0;
    int checks = 0;

    rv_lsu_ctrl #(.TIMEOUT(16)) dut (
        .i_clk       (clk),
        .i_reset_n   (i_reset_n),
        .i_valid     (i_valid),
        .i_load      (i_load),
        .i_store     (i_store),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_wsel      (i_wsel),
        .i_funct3    (i_funct3),
        .i_rd        (i_rd),
        .o_stall     (o_stall),
        .o_ld_valid  (o_ld_valid),
        .o_ld_data   (o_ld_data),
        .o_ld_rd     (o_ld_rd),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .o_bus_wsel  (o_bus_wsel),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata),
`ifdef RV_LSU_MISALIGN_EN
        .o_misalign  (o_misalign),
`endif
        .o_bus_err   (o_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_op();
        i_valid = 0; i_load = 0; i_store = 0;
        i_addr = '0; i_wdata = '0; i_wsel = '0; i_funct3 = '0; i_rd = '0;
    endtask

    task automatic set_op(input logic ld, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wsel, input logic [2:0] f3, input logic [4:0] rd);
        i_valid = 1; i_load = ld; i_store = ~ld;
        i_addr = addr; i_wdata = wdata; i_wsel = wsel; i_funct3 = f3; i_rd = rd;
    endtask

    // Runs one op with a given number of wait cycles before the ack and
    // reports what was observed; the op is held while the DUT stalls.
    task automatic run_op(input logic ld, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wsel, input logic [2:0] f3, input logic [4:0] rd,
                          input int waits, input logic [31:0] rdata,
                          output int stalls, output int ldv, output logic [31:0] ldd,
                          output logic [4:0] ldr, output logic [31:0] baddr, output logic bwe,
                          output logic [3:0] bwsel, output logic req_at_ack, output logic req_after);
        stalls = 0; ldv = 0;
        @(posedge clk); #1;
        set_op(ld, addr, wdata, wsel, f3, rd);
        i_bus_ack = 0;
        @(negedge clk);
        if (o_stall) stalls++;
        for (int w = 0; w < waits; w++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (o_stall) stalls++;
        end
        @(posedge clk); #1;
        i_bus_ack = 1; i_bus_rdata = rdata;
        @(negedge clk);
        if (o_stall) stalls++;
        baddr = o_bus_addr; bwe = o_bus_we; bwsel = o_bus_wsel; req_at_ack = o_bus_req;
        @(posedge clk); #1;
        i_bus_ack = 0; clear_op();
        @(negedge clk);
        if (o_ld_valid) ldv++;
        ldd = o_ld_data; ldr = o_ld_rd; req_after = o_bus_req;
        @(posedge clk); #1;
        @(negedge clk);
        if (o_ld_valid) ldv++;
    endtask

    task automatic test_reset();
        i_reset_n = 0; clear_op(); i_bus_ack = 0; i_bus_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", o_bus_req); end
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
        checks++; if ({o_ld_valid, o_bus_err, o_bus_we} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {o_ld_valid, o_bus_err, o_bus_we}); end
        checks++; if ({o_ld_data, o_bus_addr} !== 64'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", {o_ld_data, o_bus_addr}); end
        @(posedge clk); #1;
        i_reset_n = 1;
    endtask

    task automatic test_store();
        int st, lv; logic [31:0] d, a; logic [4:0] r; logic we, rq, rq2; logic [3:0] ws;
        run_op(1'b0, 32'h100, 32'hDEADBEEF, 4'b1111, LW, 5'd0, 0, 32'h0, st, lv, d, r, a, we, ws, rq, rq2);
        checks++; if (st !== 1) begin errors++; $display("FAIL sw_stall got=%0d exp=1", st); end
        checks++; if ({rq, we, a} !== {1'b1, 1'b1, 32'h100}) begin errors++; $display("FAIL sw_bus got=%b%b %h exp=11 00000100", rq, we, a); end
        checks++; if (o_bus_wdata !== 32'hDEADBEEF || ws !== 4'b1111) begin errors++; $display("FAIL sw_wdata got=%h/%b exp=deadbeef/1111", o_bus_wdata, ws); end
        checks++; if (lv !== 0) begin errors++; $display("FAIL sw_no_ldvalid got=%0d exp=0", lv); end
        checks++; if (rq2 !== 1'b0) begin errors++; $display("FAIL sw_req_drop got=%b exp=0", rq2); end
    endtask

    task automatic test_load_byte();
        int st, lv; logic [31:0] d, a; logic [4:0] r; logic we, rq, rq2; logic [3:0] ws;
        run_op(1'b1, 32'h103, 32'h0, 4'b0000, LB, 5'd9, 3, 32'h80FF_0000, st, lv, d, r, a, we, ws, rq, rq2);
        checks++; if (d !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", d); end
        checks++; if (st !== 4) begin errors++; $display("FAIL lb_stall got=%0d exp=4", st); end
        checks++; if (lv !== 1 || r !== 5'd9) begin errors++; $display("FAIL lb_valid_rd got=%0d/%0d exp=1/9", lv, r); end
        checks++; if ({we, ws, a} !== {1'b0, 4'b1111, 32'h100}) begin errors++; $display("FAIL lb_bus got=%b %b %h exp=0 1111 00000100", we, ws, a); end
        run_op(1'b1, 32'h101, 32'h0, 4'b0000, LB, 5'd3, 0, 32'h0000_7F00, st, lv, d, r, a, we, ws, rq, rq2);
        checks++; if (d !== 32'h0000007F) begin errors++; $display("FAIL lb_pos_data got=%h exp=0000007f", d); end
        run_op(1'b1, 32'h100, 32'h0, 4'b0000, LBU, 5'd0, 1, 32'h1234_56A5, st, lv, d, r, a, we, ws, rq, rq2);
        checks++; if ({lv, r, d} !== {32'd1, 5'd0, 32'h000000A5}) begin errors++; $display("FAIL lbu_rd0 got=%0d/%0d/%h exp=1/0/000000a5", lv, r, d); end
    endtask

    task automatic test_load_half();
        int st, lv; logic [31:0] d, a; logic [4:0] r; logic we, rq, rq2; logic [3:0] ws;
        run_op(1'b1, 32'h102, 32'h0, 4'b0000, LHU, 5'd5, 1, 32'hBEEF1234, st, lv, d, r, a, we, ws, rq, rq2);
        checks++; if (d !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_data got=%h exp=0000beef", d); end
        run_op(1'b1, 32'h102, 32'h0, 4'b0000, LH, 5'd5, 0, 32'hBEEF1234, st, lv, d, r, a, we, ws, rq, rq2);
        checks++; if (d !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_data got=%h exp=ffffbeef", d); end
        run_op(1'b1, 32'h100, 32'h0, 4'b0000, LH, 5'd5, 0, 32'hBEEF1234, st, lv, d, r, a, we, ws, rq, rq2);
        checks++; if (d !== 32'h00001234) begin errors++; $display("FAIL lh_low_data got=%h exp=00001234", d); end
    endtask

    task automatic test_misalign();
`ifdef RV_LSU_MISALIGN_EN
        int req_seen = 0;
        @(posedge clk); #1;
        set_op(1'b1, 32'h101, 32'h0, 4'b0000, LW, 5'd4);
        @(negedge clk);
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL mis_stall got=%b exp=1", o_stall); end
        @(posedge clk); #1;
        @(negedge clk);
        if (o_bus_req) req_seen++;
        checks++; if ({o_misalign, o_stall} !== 2'b10) begin errors++; $display("FAIL mis_pulse got=%b exp=10", {o_misalign, o_stall}); end
        @(posedge clk); #1;
        clear_op();
        @(negedge clk);
        if (o_bus_req) req_seen++;
        checks++; if (o_misalign !== 1'b0 || req_seen !== 0) begin errors++; $display("FAIL mis_noreq got=%b/%0d exp=0/0", o_misalign, req_seen); end
`else
        int st, lv; logic [31:0] d, a; logic [4:0] r; logic we, rq, rq2; logic [3:0] ws;
        run_op(1'b1, 32'h101, 32'h0, 4'b0000, LW, 5'd4, 0, 32'h11223344, st, lv, d, r, a, we, ws, rq, rq2);
        checks++; if ({rq, a} !== {1'b1, 32'h100}) begin errors++; $display("FAIL mis_trunc got=%b %h exp=1 00000100", rq, a); end
        checks++; if (d !== 32'h11223344 || lv !== 1) begin errors++; $display("FAIL mis_word got=%h/%0d exp=11223344/1", d, lv); end
`endif
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        set_op(1'b1, 32'h200, 32'h0, 4'b0000, LW, 5'd7);
        @(negedge clk);
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall0 got=%b exp=1", o_stall); end
        @(posedge clk); #1;
        i_bus_ack = 1; i_bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (o_stall !== 1'b0 || o_bus_req !== 1'b1) begin errors++; $display("FAIL b2b_ack got=%b%b exp=01", o_stall, o_bus_req); end
        @(posedge clk); #1;
        i_bus_ack = 0;
        set_op(1'b0, 32'h204, 32'h12345678, 4'b0011, LH, 5'd0);
        @(negedge clk);
        checks++; if ({o_ld_valid, o_ld_rd, o_ld_data} !== {1'b1, 5'd7, 32'hCAFEF00D}) begin errors++; $display("FAIL b2b_ld got=%b/%0d/%h exp=1/7/cafef00d", o_ld_valid, o_ld_rd, o_ld_data); end
        checks++; if ({o_stall, o_bus_req} !== 2'b10) begin errors++; $display("FAIL b2b_accept2 got=%b exp=10", {o_stall, o_bus_req}); end
        @(posedge clk); #1;
        i_bus_ack = 1;
        @(negedge clk);
        checks++; if ({o_bus_req, o_bus_we, o_bus_wsel, o_bus_addr} !== {1'b1, 1'b1, 4'b0011, 32'h204}) begin errors++; $display("FAIL b2b_req2 got=%b%b %b %h exp=11 0011 00000204", o_bus_req, o_bus_we, o_bus_wsel, o_bus_addr); end
        @(posedge clk); #1;
        i_bus_ack = 0; clear_op();
        @(negedge clk);
        checks++; if ({o_bus_req, o_ld_valid} !== 2'b00) begin errors++; $display("FAIL b2b_end got=%b exp=00", {o_bus_req, o_ld_valid}); end
    endtask

    task automatic test_timeout();
        logic stall_h[25], err_h[25], req_h[25];
        int first_err = -1, err_cnt = 0, ldv_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (k == 0) set_op(1'b1, 32'h300, 32'h0, 4'b0000, LW, 5'd2);
            else if (!stall_h[k-1]) clear_op();
            @(negedge clk);
            stall_h[k] = o_stall; err_h[k] = o_bus_err; req_h[k] = o_bus_req;
            if (o_bus_err) begin err_cnt++; if (first_err < 0) first_err = k; end
            if (o_ld_valid) ldv_cnt++;
        end
        checks++; if (first_err !== 17 || err_cnt !== 1) begin errors++; $display("FAIL to_err got=first %0d count %0d exp=first 17 count 1", first_err, err_cnt); end
        checks++; if ({stall_h[15], stall_h[16]} !== 2'b10) begin errors++; $display("FAIL to_stall got=%b exp=10", {stall_h[15], stall_h[16]}); end
        checks++; if ({req_h[16], req_h[17]} !== 2'b10) begin errors++; $display("FAIL to_req got=%b exp=10", {req_h[16], req_h[17]}); end
        checks++; if (ldv_cnt !== 0 || err_h[18] !== 1'b0) begin errors++; $display("FAIL to_noload got=%0d/%b exp=0/0", ldv_cnt, err_h[18]); end
    endtask

    task automatic test_reset_mid_access();
        int ldv_cnt = 0;
        @(posedge clk); #1;
        set_op(1'b1, 32'h400, 32'h0, 4'b0000, LW, 5'd6);
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (o_bus_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req_on got=%b exp=1", o_bus_req); end
        @(posedge clk); #1;
        i_reset_n = 0; clear_op();
        @(negedge clk);
        checks++; if (o_bus_req !== 1'b1) begin errors++; $display("FAIL rst_mid_sync got=%b exp=1", o_bus_req); end
        @(posedge clk); #1;
        i_reset_n = 1; i_bus_ack = 1; i_bus_rdata = 32'h55AA55AA;
        @(negedge clk);
        checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL rst_mid_drop got=%b exp=0", o_bus_req); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            i_bus_ack = 0;
            @(negedge clk);
            if (o_ld_valid || o_bus_req) ldv_cnt++;
        end
        checks++; if (ldv_cnt !== 0) begin errors++; $display("FAIL rst_mid_late_ack got=%0d exp=0", ldv_cnt); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store();
        test_load_byte();
        test_load_half();
        test_misalign();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
